// File: rtl/eeprom_arb_if.sv
// eeprom_arb_if: requester-side and EEPROM-master-side read bus of the EEPROM arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface eeprom_arb_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W = 11
);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] rsp_valid;
    logic [7:0] rsp_data;
    logic rsp_error;
    logic [ADDR_W-1:0] eep_addr;
    logic eep_read;
    logic [7:0] eep_data;
    logic eep_data_ready;
    modport slave (
        input  req_valid, req_addr, eep_data, eep_data_ready,
        output req_ready, rsp_valid, rsp_data, rsp_error, eep_addr, eep_read
    );
    modport master (
        output req_valid, req_addr, eep_data, eep_data_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_error, eep_addr, eep_read
    );
endinterface

// File: rtl/eeprom_arbiter.sv
// eeprom_arbiter: round-robin arbiter serialising reads from NUM_REQ requesters onto one EEPROM port.
// Define EEPROM_ARB_TIMEOUT_EN to compile in the WAIT-state watchdog that aborts hung reads.
module eeprom_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W = 11,
    parameter int TIMEOUT_CYCLES = 160000
) (
    input  logic clk,
    input  logic reset_n,
    eeprom_arb_if.slave bus,
    output logic busy_o
);
    localparam int GW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state_q, state_d;
    logic [GW-1:0] grant_q, grant_d, last_q, last_d, pick;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic err_q, err_d, read_q, read_d, found, tmo;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    // Search upward from the requester after the last grant, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        pick = last_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && bus.req_valid[(int'(last_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                pick = GW'((int'(last_q) + k) % NUM_REQ);
            end
        end
    end
`ifdef EEPROM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign cnt_d = state_q == WAIT ? cnt_q + 1'b1 : '0;
    assign tmo = cnt_q == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (!reset_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
`else
    // Watchdog compiled out: WAIT leaves only on eep_data_ready.
    assign tmo = TIMEOUT_CYCLES < 0;
`endif
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d = last_q;
        addr_d = addr_q;
        data_d = data_q;
        err_d = err_q;
        ready_d = '0;
        read_d = 1'b0;
        case (state_q)
            IDLE: if (found) begin
                state_d = WAIT;
                grant_d = pick;
                last_d = pick;
                addr_d = bus.req_addr[int'(pick)*ADDR_W +: ADDR_W];
                ready_d = NUM_REQ'(1) << pick;
                read_d = 1'b1;
            end
            WAIT: if (bus.eep_data_ready) begin
                state_d = RESP;
                data_d = bus.eep_data;
                err_d = 1'b0;
            end else if (tmo) begin
                state_d = RESP;
                data_d = 8'hFF;
                err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q <= GW'(NUM_REQ - 1);
            addr_q <= '0;
            data_q <= '0;
            err_q <= 1'b0;
            ready_q <= '0;
            read_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q <= last_d;
            addr_q <= addr_d;
            data_q <= data_d;
            err_q <= err_d;
            ready_q <= ready_d;
            read_q <= read_d;
        end
    end
    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = state_q == RESP ? NUM_REQ'(1) << grant_q : '0;
    assign bus.rsp_data = data_q;
    assign bus.rsp_error = err_q;
    assign bus.eep_addr = addr_q;
    assign bus.eep_read = read_q;
    assign busy_o = state_q != IDLE;
endmodule

// File: tb/tb_eeprom_arbiter.sv
// tb_eeprom_arbiter: directed self-checking bench for eeprom_arbiter with a fixed-latency EEPROM model.
// Timeout scenarios run only when EEPROM_ARB_TIMEOUT_EN is defined.
module tb_eeprom_arbiter;
    localparam int N = 3;
    localparam int AW = 11;
    localparam int TO = 100;
    logic clk = 1'b0;
    logic reset_n;
    logic busy;
    logic model_rdy = 1'b0;
    logic spur_rdy;
    int tests = 0;
    int fails = 0;
    int m_lat = 2;
    int m_cnt = 0;
    bit m_en = 1'b1;
    bit m_armed = 1'b0;
    eeprom_arb_if #(.NUM_REQ(N), .ADDR_W(AW)) bus ();
    eeprom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave),
        .busy_o(busy)
    );
    always #5 clk = ~clk;
    assign bus.eep_data_ready = model_rdy | spur_rdy;
    // EEPROM model: completion strobe m_lat cycles after the cycle carrying eep_read.
    always @(negedge clk) begin
        model_rdy = 1'b0;
        if (!reset_n) m_armed = 1'b0;
        else if (m_armed) begin
            m_cnt--;
            if (m_cnt == 0) begin
                model_rdy = 1'b1;
                m_armed = 1'b0;
            end
        end else if (bus.eep_read && m_en) begin
            if (m_lat == 0) model_rdy = 1'b1;
            else begin
                m_cnt = m_lat;
                m_armed = 1'b1;
            end
        end
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    // Cycle 1 is the current cycle; returns at the first cycle with rsp_valid (cyc=-1 if none).
    task automatic run_until_rsp(input bit keep, output int cyc, output int rd_cyc, output int rd_cnt,
                                 output logic [AW-1:0] rd_addr, output logic [N-1:0] rdy);
        cyc = 1;
        rd_cyc = 0;
        rd_cnt = 0;
        rd_addr = '0;
        rdy = '0;
        while (cyc < 400) begin
            tick;
            cyc++;
            if (bus.eep_read) begin
                rd_cnt++;
                if (rd_cyc == 0) begin
                    rd_cyc = cyc;
                    rd_addr = bus.eep_addr;
                end
            end
            if (bus.req_ready != '0) begin
                rdy |= bus.req_ready;
                if (!keep) bus.req_valid = bus.req_valid & ~bus.req_ready;
            end
            if (bus.rsp_valid != '0) return;
        end
        cyc = -1;
    endtask
    task automatic test_reset;
        logic [2*N+AW+10:0] v;
        int reads, rsps;
        logic [7:0] d;
        reset_n = 1'b0;
        bus.req_valid = '1;
        bus.req_addr = {11'h300, 11'h200, 11'h100};
        bus.eep_data = 8'h11;
        m_lat = 2;
        for (int i = 0; i < 3; i++) begin
            tick;
            v = {bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_error, busy, bus.eep_read, bus.eep_addr};
            tests++;
            if (v !== '0) begin fails++; $display("FAIL reset_outputs cycle %0d: got %h expected 0", i, v); end
        end
        reset_n = 1'b1;
        tick;
        tests++;
        if (bus.req_ready !== 3'b001) begin fails++; $display("FAIL reset_first_grant: got %b expected 001", bus.req_ready); end
        tests++;
        if (bus.eep_read !== 1'b1) begin fails++; $display("FAIL reset_first_read: got %b expected 1", bus.eep_read); end
        tests++;
        if (bus.eep_addr !== 11'h100) begin fails++; $display("FAIL reset_first_addr: got %h expected 100", bus.eep_addr); end
        bus.req_valid = '0;
        reads = 0;
        rsps = 0;
        d = '0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (bus.eep_read) reads++;
            if (bus.rsp_valid == 3'b001) begin rsps++; d = bus.rsp_data; end
        end
        tests++;
        if (reads != 0) begin fails++; $display("FAIL reset_single_strobe: got %0d extra reads expected 0", reads); end
        tests++;
        if (rsps != 1 || d !== 8'h11) begin fails++; $display("FAIL reset_first_rsp: got %0d rsp data %h expected 1 rsp data 11", rsps, d); end
    endtask
    task automatic test_single;
        int cyc, rd_cyc, rd_cnt;
        logic [AW-1:0] a;
        logic [N-1:0] rdy;
        bus.req_addr = {11'h7FF, 11'h010, 11'h123};
        bus.req_valid = 3'b010;
        bus.eep_data = 8'hA5;
        m_lat = 40;
        run_until_rsp(1'b0, cyc, rd_cyc, rd_cnt, a, rdy);
        tests++;
        if (rdy !== 3'b010) begin fails++; $display("FAIL single_ready: got %b expected 010", rdy); end
        tests++;
        if (rd_cyc != 2 || rd_cnt != 1) begin fails++; $display("FAIL single_read: got cycle %0d count %0d expected cycle 2 count 1", rd_cyc, rd_cnt); end
        tests++;
        if (a !== 11'h010) begin fails++; $display("FAIL single_addr: got %h expected 010", a); end
        tests++;
        if (cyc != 43) begin fails++; $display("FAIL single_latency: got %0d expected 43", cyc); end
        tests++;
        if (bus.rsp_valid !== 3'b010) begin fails++; $display("FAIL single_rsp_valid: got %b expected 010", bus.rsp_valid); end
        tests++;
        if (bus.rsp_data !== 8'hA5 || bus.rsp_error !== 1'b0) begin fails++; $display("FAIL single_rsp_data: got %h err %b expected a5 err 0", bus.rsp_data, bus.rsp_error); end
        tests++;
        if (bus.eep_addr !== 11'h010) begin fails++; $display("FAIL single_addr_held: got %h expected 010", bus.eep_addr); end
        tick;
        tests++;
        if (busy !== 1'b0 || bus.rsp_valid !== 3'b000) begin fails++; $display("FAIL single_back_idle: got busy %b rsp %b expected 0 000", busy, bus.rsp_valid); end
    endtask
    task automatic test_fairness;
        int cyc, rd_cyc, rd_cnt;
        logic [AW-1:0] a;
        logic [N-1:0] rdy, exp_v;
        logic [AW-1:0] addrs [N];
        addrs[0] = 11'h0A0;
        addrs[1] = 11'h1B1;
        addrs[2] = 11'h2C2;
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        bus.req_addr = {addrs[2], addrs[1], addrs[0]};
        bus.req_valid = 3'b111;
        m_lat = 5;
        for (int i = 0; i < 6; i++) begin
            bus.eep_data = 8'h40 + 8'(i);
            exp_v = 3'b001 << (i % 3);
            run_until_rsp(1'b1, cyc, rd_cyc, rd_cnt, a, rdy);
            if (i == 5) bus.req_valid = '0;
            tests++;
            if (rdy !== exp_v || bus.rsp_valid !== exp_v) begin fails++; $display("FAIL fair_order read %0d: got grant %b rsp %b expected %b", i, rdy, bus.rsp_valid, exp_v); end
            tests++;
            if (a !== addrs[i % 3] || bus.rsp_data !== 8'h40 + 8'(i)) begin fails++; $display("FAIL fair_payload read %0d: got addr %h data %h expected %h %h", i, a, bus.rsp_data, addrs[i % 3], 8'h40 + 8'(i)); end
            tests++;
            if (rd_cyc != (i == 0 ? 2 : 3)) begin fails++; $display("FAIL fair_gap read %0d: got read at %0d expected %0d", i, rd_cyc, i == 0 ? 2 : 3); end
        end
        tick;
        tick;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL fair_drain: got busy %b expected 0", busy); end
    endtask
    task automatic test_spurious;
        int cyc, rd_cyc, rd_cnt;
        logic [AW-1:0] a;
        logic [N-1:0] rdy;
        spur_rdy = 1'b1;
        bus.eep_data = 8'hEE;
        tick;
        spur_rdy = 1'b0;
        tests++;
        if (bus.rsp_valid !== 3'b000 || busy !== 1'b0 || bus.eep_read !== 1'b0) begin fails++; $display("FAIL spur_idle: got rsp %b busy %b read %b expected 000 0 0", bus.rsp_valid, busy, bus.eep_read); end
        bus.req_addr = {11'h555, 11'h000, 11'h000};
        bus.req_valid = 3'b100;
        bus.eep_data = 8'h77;
        m_lat = 3;
        run_until_rsp(1'b0, cyc, rd_cyc, rd_cnt, a, rdy);
        tests++;
        if (bus.rsp_valid !== 3'b100 || bus.rsp_data !== 8'h77) begin fails++; $display("FAIL spur_read: got rsp %b data %h expected 100 77", bus.rsp_valid, bus.rsp_data); end
        spur_rdy = 1'b1;
        bus.eep_data = 8'hEE;
        tick;
        spur_rdy = 1'b0;
        tests++;
        if (bus.rsp_valid !== 3'b000 || busy !== 1'b0 || bus.rsp_data !== 8'h77) begin fails++; $display("FAIL spur_resp: got rsp %b busy %b data %h expected 000 0 77", bus.rsp_valid, busy, bus.rsp_data); end
        tick;
        tests++;
        if (bus.rsp_valid !== 3'b000 || busy !== 1'b0) begin fails++; $display("FAIL spur_after: got rsp %b busy %b expected 000 0", bus.rsp_valid, busy); end
    endtask
    task automatic test_reset_mid;
        bit bad;
        m_en = 1'b0;
        bus.req_valid = 3'b001;
        tick;
        bus.req_valid = '0;
        tests++;
        if (bus.eep_read !== 1'b1) begin fails++; $display("FAIL mid_read: got %b expected 1", bus.eep_read); end
        repeat (10) tick;
        tests++;
        if (busy !== 1'b1 || bus.rsp_valid !== 3'b000) begin fails++; $display("FAIL mid_waiting: got busy %b rsp %b expected 1 000", busy, bus.rsp_valid); end
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        tests++;
        if (busy !== 1'b0 || bus.rsp_valid !== 3'b000) begin fails++; $display("FAIL mid_reset: got busy %b rsp %b expected 0 000", busy, bus.rsp_valid); end
        bad = 1'b0;
        repeat (5) begin
            tick;
            if (busy !== 1'b0 || bus.rsp_valid !== 3'b000) bad = 1'b1;
        end
        tests++;
        if (bad) begin fails++; $display("FAIL mid_no_rsp: got late activity %b expected 0", bad); end
        m_en = 1'b1;
    endtask
`ifdef EEPROM_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int cyc, rd_cyc, rd_cnt;
        logic [AW-1:0] a;
        logic [N-1:0] rdy;
        m_en = 1'b0;
        bus.req_addr = {11'h3AB, 11'h000, 11'h012};
        bus.req_valid = 3'b100;
        run_until_rsp(1'b0, cyc, rd_cyc, rd_cnt, a, rdy);
        m_en = 1'b1;
        tests++;
        if (cyc != 102) begin fails++; $display("FAIL tmo_cycle: got %0d expected 102", cyc); end
        tests++;
        if (bus.rsp_valid !== 3'b100 || bus.rsp_error !== 1'b1 || bus.rsp_data !== 8'hFF) begin fails++; $display("FAIL tmo_rsp: got rsp %b err %b data %h expected 100 1 ff", bus.rsp_valid, bus.rsp_error, bus.rsp_data); end
        bus.req_valid = 3'b001;
        bus.eep_data = 8'h3C;
        m_lat = 2;
        run_until_rsp(1'b0, cyc, rd_cyc, rd_cnt, a, rdy);
        tests++;
        if (bus.rsp_valid !== 3'b001 || bus.rsp_error !== 1'b0 || bus.rsp_data !== 8'h3C || a !== 11'h012) begin fails++; $display("FAIL tmo_resume: got rsp %b err %b data %h addr %h expected 001 0 3c 012", bus.rsp_valid, bus.rsp_error, bus.rsp_data, a); end
    endtask
    task automatic test_coincide;
        int cyc, rd_cyc, rd_cnt;
        logic [AW-1:0] a;
        logic [N-1:0] rdy;
        tick;
        bus.req_valid = 3'b010;
        bus.eep_data = 8'h5A;
        m_lat = 99;
        run_until_rsp(1'b0, cyc, rd_cyc, rd_cnt, a, rdy);
        tests++;
        if (cyc != 102) begin fails++; $display("FAIL coincide_cycle: got %0d expected 102", cyc); end
        tests++;
        if (bus.rsp_valid !== 3'b010 || bus.rsp_error !== 1'b0 || bus.rsp_data !== 8'h5A) begin fails++; $display("FAIL coincide_rsp: got rsp %b err %b data %h expected 010 0 5a", bus.rsp_valid, bus.rsp_error, bus.rsp_data); end
    endtask
`endif
    initial begin
        reset_n = 1'b0;
        spur_rdy = 1'b0;
        bus.req_valid = '0;
        bus.req_addr = '0;
        bus.eep_data = '0;
        test_reset;
        test_single;
        test_fairness;
        test_spurious;
        test_reset_mid;
`ifdef EEPROM_ARB_TIMEOUT_EN
        test_timeout;
        test_coincide;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
